gyro_rd_ctrl: RTL

Control stage that sits directly upstream of the yaw integrator and calibration logic.
- After reset it programs the inertial sensor through the SPI transceiver handshake.
- It then services every sensor data-ready interrupt by reading the yaw-rate low and high bytes.
- Each completed read presents a signed 16-bit yaw rate with a one-cycle valid strobe to the downstream integrator.

---
 rtl/gyro_rd_ctrl_if.sv | 10 +
 rtl/gyro_rd_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/gyro_rd_ctrl_if.sv
// SPI transceiver handshake between gyro_rd_ctrl (master) and the transceiver (slave).
interface gyro_rd_ctrl_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/gyro_rd_ctrl.sv
// Gyro read controller: programs the sensor after power-up, then reads the yaw
// rate (low byte, then high byte) on every data-ready interrupt.
module gyro_rd_ctrl #(
    parameter int          INIT_WAIT_BITS = 16,
    parameter logic [15:0] CMD_INT_EN     = 16'h0D02,
    parameter logic [15:0] CMD_GYRO_CFG   = 16'h1160,
    parameter logic [15:0] CMD_ROUND      = 16'h1440,
    parameter logic [15:0] CMD_YAW_L      = 16'hA600,
    parameter logic [15:0] CMD_YAW_H      = 16'hA700
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  INT,
    gyro_rd_ctrl_if.master        spi,
    output logic                  init_done,
    output logic [15:0]           yaw_rt,
    output logic                  vld
);

    typedef enum logic [2:0] {
        WAIT_PWR, INIT1, INIT2, INIT3, IDLE, RD_L, RD_H
    } state_t;

    state_t                    state, nxt_state;
    logic [INIT_WAIT_BITS-1:0] pwr_cnt;
    logic                      int_ff1, int_ff2;
    logic [7:0]                low_byte;
    logic                      wrt_nxt;
    logic [15:0]               cmd_nxt;
    logic                      set_init, cap_low, upd_yaw;

    // Only the low byte of a response carries data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^spi.rd_data[15:8];

    always_comb begin
        nxt_state = state;
        wrt_nxt   = 1'b0;
        cmd_nxt   = spi.cmd;
        set_init  = 1'b0;
        cap_low   = 1'b0;
        upd_yaw   = 1'b0;
        case (state)
            WAIT_PWR: if (&pwr_cnt) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = CMD_INT_EN;
                nxt_state = INIT1;
            end
            INIT1: if (spi.done) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = CMD_GYRO_CFG;
                nxt_state = INIT2;
            end
            INIT2: if (spi.done) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = CMD_ROUND;
                nxt_state = INIT3;
            end
            INIT3: if (spi.done) begin
                set_init  = 1'b1;
                nxt_state = IDLE;
            end
            IDLE: if (int_ff2) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = CMD_YAW_L;
                nxt_state = RD_L;
            end
            RD_L: if (spi.done) begin
                cap_low   = 1'b1;
                wrt_nxt   = 1'b1;
                cmd_nxt   = CMD_YAW_H;
                nxt_state = RD_H;
            end
            RD_H: if (spi.done) begin
                upd_yaw   = 1'b1;
                nxt_state = IDLE;
            end
            default: nxt_state = WAIT_PWR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_PWR;
            pwr_cnt   <= '0;
            int_ff1   <= 1'b0;
            int_ff2   <= 1'b0;
            low_byte  <= 8'h00;
            spi.wrt   <= 1'b0;
            spi.cmd   <= 16'h0000;
            init_done <= 1'b0;
            yaw_rt    <= 16'h0000;
            vld       <= 1'b0;
        end else begin
            state   <= nxt_state;
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            // Saturates at all ones; the FSM leaves WAIT_PWR on that same cycle.
            if (state == WAIT_PWR && !(&pwr_cnt))
                pwr_cnt <= pwr_cnt + 1'b1;
            spi.wrt <= wrt_nxt;
            spi.cmd <= cmd_nxt;
            if (set_init)
                init_done <= 1'b1;
            if (cap_low)
                low_byte <= spi.rd_data[7:0];
            vld <= upd_yaw;
            if (upd_yaw)
                yaw_rt <= {spi.rd_data[7:0], low_byte};
        end
    end

endmodule
